// File: rtl/trigger_event_arbiter_pkg.sv
// Shared constants for the trigger event arbiter: channel FSM encoding and
// the helper used to validate the event id width.
package trigger_event_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  // Smallest number of bits that can index n sources (at least 1).
  function automatic int id_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction

endpackage

// File: rtl/trigger_event_arbiter_rise.sv
// Single-bit rising-edge pulse generator: a 2-stage history of the input,
// pulsing for exactly one cycle after the input is first sampled high.
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  // hist_q[0] holds the newest sample, hist_q[1] the one before it.
  logic [1:0] hist_q;
  logic [1:0] hist_d;

  assign hist_d = {hist_q[0], d_i};

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 2'b00;
    else     hist_q <= hist_d;
  end

  assign rise_o = (hist_q == 2'b01);

endmodule

// File: rtl/trigger_event_arbiter.sv
// Turns source rising edges into pending events and serves them one at a
// time, round-robin, over a valid/ready event channel with overflow flags.
module trigger_event_arbiter
  import trigger_event_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_i,
  input  logic [N_SRC-1:0] enable_i,
  output logic             evt_valid_o,
  output logic [ID_W-1:0]  evt_id_o,
  input  logic             evt_ready_i,
  output logic [N_SRC-1:0] overflow_o,
  input  logic             clear_i
);

  localparam int ID_W_MIN = id_bits(N_SRC);

  if (ID_W < ID_W_MIN || N_SRC < 2 || N_SRC > 8) begin : g_bad_param
    $error("trigger_event_arbiter: N_SRC must be 2..8 and ID_W wide enough to index it");
  end

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] arm;
  logic [N_SRC-1:0] ovf_set;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] overflow_q, overflow_d;
  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic             hs;

  for (genvar i = 0; i < N_SRC; i++) begin : g_rise
    rise_pulse u_rise (
      .clk    (clk),
      .rst    (rst),
      .d_i    (src_i[i]),
      .rise_o (rise[i])
    );
  end

  assign arm = rise & enable_i;
  assign hs  = (state_q == ST_OFFER) && evt_ready_i;

  // First requester strictly after last, wrapping from N_SRC-1 back to 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                              input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(last) + k) % N_SRC;
      if (!found && req[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pending_d = pending_q | arm;
    ovf_set   = arm & pending_q;
    for (int i = 0; i < N_SRC; i++) begin
      // A rise landing on the handshake cycle of its own source is a fresh event.
      if (hs && id_q == ID_W'(i)) begin
        pending_d[i] = arm[i];
        ovf_set[i]   = 1'b0;
      end
    end
    overflow_d = (clear_i ? '0 : overflow_q) | ovf_set;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          id_d    = rr_pick(pending_q, last_q);
          state_d = ST_OFFER;
        end
      end
      default: begin
        if (evt_ready_i) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= '0;
      state_q    <= ST_IDLE;
      id_q       <= '0;
      last_q     <= ID_W'(N_SRC - 1);
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      id_q       <= id_d;
      last_q     <= last_d;
    end
  end

  assign evt_valid_o = (state_q == ST_OFFER);
  assign evt_id_o    = id_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_trigger_event_arbiter.sv
// Directed bench for trigger_event_arbiter (N_SRC=4, ID_W=2); outputs are
// sampled 1 time unit after each rising clock edge.
module tb_trigger_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] src = '0;
  logic [3:0] en = 4'b1111;
  logic       ready = 1'b0;
  logic       clear = 1'b0;
  logic       valid;
  logic [1:0] id;
  logic [3:0] ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trigger_event_arbiter #(.N_SRC(4), .ID_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_i       (src),
    .enable_i    (en),
    .evt_valid_o (valid),
    .evt_id_o    (id),
    .evt_ready_i (ready),
    .overflow_o  (ovf),
    .clear_i     (clear)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    src   = '0;
    clear = 1'b0;
    en    = 4'b1111;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({valid, id, ovf} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b id=%0d ovf=%b, want all zero", valid, id, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_source();
    apply_reset();
    ready = 1'b1;
    src[2] = 1'b1;
    step();
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: valid=%b want 0", valid);
    end
    step();
    checks++;
    if (valid !== 1'b1 || id !== 2'd2) begin
      errors++;
      $display("FAIL single_offer: valid=%b id=%0d want 1/2", valid, id);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after_hs: valid=%b want 0", valid);
    end
    src[2] = 1'b0;
    step();
    step();
  endtask

  task automatic test_round_robin();
    logic exp_v [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   exp_id[6] = '{0, 0, 1, 0, 3, 0};
    apply_reset();
    ready = 1'b1;
    for (int burst = 0; burst < 2; burst++) begin
      src = 4'b1011;
      step();
      step();
      for (int j = 0; j < 6; j++) begin
        step();
        checks++;
        if (valid !== exp_v[j] || (exp_v[j] && id !== 2'(exp_id[j]))) begin
          errors++;
          $display("FAIL rr_burst%0d_cycle%0d: valid=%b id=%0d want %b/%0d",
                   burst, j, valid, id, exp_v[j], exp_id[j]);
        end
      end
      src = '0;
      step();
      step();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    ready = 1'b0;
    src = 4'b0010;
    step();
    step();
    step();
    checks++;
    if (valid !== 1'b1 || id !== 2'd1) begin
      errors++;
      $display("FAIL bp_offer: valid=%b id=%0d want 1/1", valid, id);
    end
    for (int c = 0; c < 20; c++) begin
      if (c == 3) src[1] = 1'b0;
      if (c == 5) src[1] = 1'b1;
      step();
      checks++;
      if (valid !== 1'b1 || id !== 2'd1) begin
        errors++;
        $display("FAIL bp_stall_%0d: valid=%b id=%0d want 1/1", c, valid, id);
      end
    end
    checks++;
    if (ovf !== 4'b0010) begin
      errors++;
      $display("FAIL bp_overflow: ovf=%b want 0010", ovf);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin
      errors++;
      $display("FAIL bp_clear: ovf=%b want 0000", ovf);
    end
    // Overflow in the same cycle as clear: set wins.
    src[1] = 1'b0;
    step();
    src[1] = 1'b1;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (ovf !== 4'b0010) begin
      errors++;
      $display("FAIL bp_set_wins: ovf=%b want 0010", ovf);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (ovf !== 4'b0000 || valid !== 1'b1 || id !== 2'd1) begin
      errors++;
      $display("FAIL bp_clear2: ovf=%b valid=%b id=%0d want 0000/1/1", ovf, valid, id);
    end
    ready = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: valid=%b want 0", valid);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_double: valid=%b want 0", valid);
    end
    src = '0;
    step();
  endtask

  task automatic test_enable_mask();
    apply_reset();
    ready = 1'b1;
    en = 4'b1110;
    src = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL en_masked_%0d: valid=%b want 0", c, valid);
      end
    end
    src = '0;
    step();
    step();
    en = 4'b1111;
    src = 4'b0001;
    step();
    step();
    en = 4'b1110;
    step();
    checks++;
    if (valid !== 1'b1 || id !== 2'd0) begin
      errors++;
      $display("FAIL en_late_disable: valid=%b id=%0d want 1/0", valid, id);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL en_after_hs: valid=%b want 0", valid);
    end
    en = 4'b1111;
    src = '0;
    step();
    step();
  endtask

  task automatic test_same_cycle_rise();
    apply_reset();
    ready = 1'b0;
    src = 4'b1000;
    step();
    step();
    step();
    checks++;
    if (valid !== 1'b1 || id !== 2'd3) begin
      errors++;
      $display("FAIL same_first_offer: valid=%b id=%0d want 1/3", valid, id);
    end
    src = '0;
    step();
    src = 4'b1000;
    step();
    ready = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0 || ovf !== 4'b0000) begin
      errors++;
      $display("FAIL same_hs: valid=%b ovf=%b want 0/0000", valid, ovf);
    end
    step();
    checks++;
    if (valid !== 1'b1 || id !== 2'd3) begin
      errors++;
      $display("FAIL same_second_offer: valid=%b id=%0d want 1/3", valid, id);
    end
    step();
    checks++;
    if (valid !== 1'b0 || ovf !== 4'b0000) begin
      errors++;
      $display("FAIL same_done: valid=%b ovf=%b want 0/0000", valid, ovf);
    end
    src = '0;
    step();
  endtask

  task automatic test_async_reset();
    apply_reset();
    ready = 1'b0;
    src = 4'b0100;
    step();
    step();
    step();
    src = '0;
    step();
    src = 4'b0100;
    step();
    step();
    checks++;
    if (valid !== 1'b1 || id !== 2'd2 || ovf !== 4'b0100) begin
      errors++;
      $display("FAIL ar_setup: valid=%b id=%0d ovf=%b want 1/2/0100", valid, id, ovf);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || ovf !== 4'b0000 || id !== 2'd0) begin
      errors++;
      $display("FAIL ar_async: valid=%b id=%0d ovf=%b want 0/0/0000", valid, id, ovf);
    end
    src = '0;
    step();
    rst = 1'b0;
    ready = 1'b1;
    src = 4'b1001;
    step();
    step();
    step();
    checks++;
    if (valid !== 1'b1 || id !== 2'd0) begin
      errors++;
      $display("FAIL ar_first_grant: valid=%b id=%0d want 1/0", valid, id);
    end
    step();
    step();
    checks++;
    if (valid !== 1'b1 || id !== 2'd3) begin
      errors++;
      $display("FAIL ar_second_grant: valid=%b id=%0d want 1/3", valid, id);
    end
    src = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_enable_mask();
    test_same_cycle_rise();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
